input_process_spi: RTL and testbench
====================================

# input_process_spi

Receive side of the inter-board serial message link. The block deserializes the 1-bit stream on RX_DATA into 16-bit words, using RX_LOAD as the last-bit word delimiter. It frames fixed 6-word messages that start with header 16'h55AA and presents the command word and 64-bit payload to the control logic with a one-cycle valid strobe. It sits between the board's serial input pins and the mode/command handling logic, mirroring the transmit path that sends the board-mode message.

## Interface
Parameters:
- HEADER, 16'h55AA: first word of every message.
- BOARD_MODE_CMD, 16'h0082: command code that raises BOARD_MODE_REQ.
- TIMEOUT, 1024: maximum RX_CLK cycles allowed between consecutive word strobes inside a message. Range 16..65535.

Ports:
- RST  in  1  asynchronous, active-low reset.
- RX_CLK  in  1  clock. One serial bit per rising edge.
- RX_DATA  in  1  serial data, MSB first.
- RX_LOAD  in  1  high on the same cycle as bit 0 (the last bit) of each word.
- MSG_VALID  out  1  one-cycle pulse when a complete message is available.
- MSG_CMD  out  16  word 1 of the last accepted message.
- MSG_PAYLOAD  out  64  words 2..5 of the last accepted message. Word 2 occupies bits [63:48]; word 5 occupies bits [15:0].
- BOARD_MODE_REQ  out  1  one-cycle pulse, coincident with MSG_VALID, when MSG_CMD == BOARD_MODE_CMD.
- MSG_ERR  out  1  one-cycle pulse when a partial message is aborted by timeout.

## Operation
- Shift register: 16 bits, shifts RX_DATA in on every cycle regardless of RX_LOAD.
- Word capture: on a cycle where RX_LOAD=1, capture word = {shreg[14:0], RX_DATA}. word_valid is registered high on the following cycle.
- Parser FSM, three states:
  - HUNT: discard words until word == HEADER, then go to CMD. Non-header words are dropped silently with no error.
  - CMD: the next word is stored as the command; go to PAYLOAD with word index k=0.
  - PAYLOAD: store words k=0..3. When the 4th payload word is stored (k=3), return to HUNT and raise MSG_VALID for one cycle.
- A HEADER value that appears in the CMD or PAYLOAD position is treated as data. The parser does not resync on it.
- MSG_CMD and MSG_PAYLOAD update only when MSG_VALID is asserted, and hold their values until the next accepted message. Partial messages never alter them.
- Timeout counter:
  - Cleared on every word_valid.
  - Counts while the FSM is in CMD or PAYLOAD.
  - When the count reaches TIMEOUT-1 with no word_valid, the FSM returns to HUNT and MSG_ERR pulses for one cycle.
  - The counter does not run in HUNT.
- Simultaneous timeout expiry and word_valid: the word wins. The counter clears, the word is accepted, and no error is raised.

## Timing
- Reset values: MSG_VALID=0, BOARD_MODE_REQ=0, MSG_ERR=0, MSG_CMD=16'h0000, MSG_PAYLOAD=64'h0. Shift register is 0, FSM is in HUNT, counters are 0.
- Reset asserted mid-message: the partial message is discarded and outputs return to their reset values immediately (asynchronous reset).
- Latency: the RX_LOAD cycle of word 5 is cycle N. word_valid is at N+1. MSG_VALID, BOARD_MODE_REQ and the updated MSG_CMD/MSG_PAYLOAD are all registered and visible at N+2.
- Back-to-back words (RX_LOAD every 16 cycles) and back-to-back messages with zero idle gap must be sustained.
- Minimum RX_LOAD spacing: 16 cycles. Closer strobes capture overlapping bits; this is not detected and not an error.

## Structure
- Shared package or header holds HEADER, BOARD_MODE_CMD, the FSM state encodings, and the message length constants (6 words, 4 payload words). The transmit path uses the same constants.
- Sub-module deserializer: shift register plus RX_LOAD capture, with outputs word[15:0] and word_valid. The top level contains the FSM, the timeout counter and the output registers.

## Test plan
- Board-mode message: send 55AA 0082 0001 1000 0000 0000 back-to-back. Expect MSG_VALID and BOARD_MODE_REQ 2 cycles after the last RX_LOAD, MSG_CMD=0082, MSG_PAYLOAD=64'h0001_1000_0000_0000.
- Leading garbage: send 1234 ABCD, then a full message with cmd 0005 and payload 1111 2222 3333 4444. Expect one MSG_VALID, MSG_CMD=0005, BOARD_MODE_REQ=0, MSG_ERR never pulsed.
- Timeout: send 55AA 0082 0001, then idle for TIMEOUT cycles. Expect MSG_ERR pulse, no MSG_VALID, and MSG_CMD/MSG_PAYLOAD unchanged. A following full message is then accepted.
- Header as data: send 55AA 0003 55AA 0000 0000 0001. Expect MSG_VALID with MSG_PAYLOAD=64'h55AA_0000_0000_0001.
- Reset mid-message: pull RST low after 3 words, release it, then send a full message. Expect outputs at zero during reset and exactly one MSG_VALID carrying the second message's contents.
- Gap at the limit: insert a gap of TIMEOUT-1 cycles between payload words. Expect the message to be accepted and no MSG_ERR.

Source files
------------

// File: rtl/input_process_spi_pkg.sv
// Shared constants and types for the inter-board serial message link.
// The transmit path uses the same header, command codes and message sizes.
package input_process_spi_pkg;

  localparam int unsigned C_WORD_BITS      = 16;
  localparam int unsigned C_MSG_WORDS      = 6;
  localparam int unsigned C_PAYLOAD_WORDS  = C_MSG_WORDS - 2;
  localparam int unsigned C_PAYLOAD_BITS   = C_PAYLOAD_WORDS * C_WORD_BITS;

  localparam logic [15:0] C_HEADER         = 16'h55AA;
  localparam logic [15:0] C_BOARD_MODE_CMD = 16'h0082;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CMD     = 2'd1,
    ST_PAYLOAD = 2'd2
  } parser_state_t;

endpackage

// File: rtl/input_process_spi_deser.sv
// Serial-to-word deserializer: shifts one bit per clock, MSB first, and
// captures a 16-bit word on the cycle carrying its last bit (i_load high).
module input_process_spi_deser
  import input_process_spi_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_data,
  input  logic                   i_load,
  output logic [C_WORD_BITS-1:0] o_word,
  output logic                   o_word_valid
);

  logic [C_WORD_BITS-2:0] r_shreg;
  logic [C_WORD_BITS-1:0] r_word;
  logic                   r_word_valid;
  logic [C_WORD_BITS-1:0] w_window;

  // The 16-bit window is the 15 previously shifted bits plus the current bit.
  assign w_window = {r_shreg, i_data};

  // Shift every cycle, independent of the word delimiter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shreg <= '0;
    end else begin
      r_shreg <= w_window[C_WORD_BITS-2:0];
    end
  end

  // Capture the completed word and flag it valid on the following cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= i_load;
      if (i_load) begin
        r_word <= w_window;
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;

endmodule

// File: rtl/input_process_spi.sv
// Receive side of the inter-board message link: frames 6-word messages
// (header, command, 4 payload words), presents command and payload with a
// one-cycle valid strobe, and aborts partial messages on an inter-word timeout.
module input_process_spi
  import input_process_spi_pkg::*;
#(
  parameter logic [15:0] HEADER         = C_HEADER,
  parameter logic [15:0] BOARD_MODE_CMD = C_BOARD_MODE_CMD,
  parameter int unsigned TIMEOUT        = 1024
)
(
  input  logic                      RST,
  input  logic                      RX_CLK,
  input  logic                      RX_DATA,
  input  logic                      RX_LOAD,
  output logic                      MSG_VALID,
  output logic [C_WORD_BITS-1:0]    MSG_CMD,
  output logic [C_PAYLOAD_BITS-1:0] MSG_PAYLOAD,
  output logic                      BOARD_MODE_REQ,
  output logic                      MSG_ERR
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [1:0]  LAST_K  = 2'(C_PAYLOAD_WORDS - 1);

  logic [C_WORD_BITS-1:0]    w_word;
  logic                      w_word_valid;

  parser_state_t             r_state;
  parser_state_t             w_next_state;
  logic [1:0]                r_kidx;
  logic [15:0]               r_cnt;
  logic [C_WORD_BITS-1:0]    r_cmd_stage;
  logic [C_PAYLOAD_BITS-C_WORD_BITS-1:0] r_pay_stage;

  logic                      r_msg_valid;
  logic [C_WORD_BITS-1:0]    r_msg_cmd;
  logic [C_PAYLOAD_BITS-1:0] r_msg_payload;
  logic                      r_bmr;
  logic                      r_err;

  logic                      w_store_cmd;
  logic                      w_store_pay;
  logic                      w_accept;
  logic                      w_timeout;

  input_process_spi_deser u_deser (
    .i_clk        (RX_CLK),
    .i_rst_n      (RST),
    .i_data       (RX_DATA),
    .i_load       (RX_LOAD),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // Parser state register.
  always_ff @(posedge RX_CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; an arriving word always takes priority over timeout.
  always_comb begin
    w_next_state = r_state;
    w_store_cmd  = 1'b0;
    w_store_pay  = 1'b0;
    w_accept     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (w_word_valid && (w_word == HEADER)) begin
          w_next_state = ST_CMD;
        end
      end
      ST_CMD: begin
        if (w_word_valid) begin
          w_store_cmd  = 1'b1;
          w_next_state = ST_PAYLOAD;
        end else if (r_cnt == TO_LAST) begin
          w_timeout    = 1'b1;
          w_next_state = ST_HUNT;
        end
      end
      ST_PAYLOAD: begin
        if (w_word_valid) begin
          w_store_pay = 1'b1;
          if (r_kidx == LAST_K) begin
            w_accept     = 1'b1;
            w_next_state = ST_HUNT;
          end
        end else if (r_cnt == TO_LAST) begin
          w_timeout    = 1'b1;
          w_next_state = ST_HUNT;
        end
      end
      default: begin
        w_next_state = ST_HUNT;
      end
    endcase
  end

  // Inter-word timeout counter; idle in HUNT, cleared on every word.
  always_ff @(posedge RX_CLK or negedge RST) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (w_word_valid || w_timeout || (r_state == ST_HUNT)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Staging of command and the first payload words of the message in flight.
  always_ff @(posedge RX_CLK or negedge RST) begin
    if (!RST) begin
      r_kidx      <= '0;
      r_cmd_stage <= '0;
      r_pay_stage <= '0;
    end else begin
      if (w_store_cmd) begin
        r_cmd_stage <= w_word;
        r_kidx      <= '0;
      end
      if (w_store_pay) begin
        r_pay_stage <= {r_pay_stage[C_PAYLOAD_BITS-2*C_WORD_BITS-1:0], w_word};
        r_kidx      <= r_kidx + 2'd1;
      end
    end
  end

  // Output registers: only a completed message updates command and payload.
  always_ff @(posedge RX_CLK or negedge RST) begin
    if (!RST) begin
      r_msg_valid   <= 1'b0;
      r_msg_cmd     <= '0;
      r_msg_payload <= '0;
      r_bmr         <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_msg_valid <= w_accept;
      r_bmr       <= w_accept && (r_cmd_stage == BOARD_MODE_CMD);
      r_err       <= w_timeout;
      if (w_accept) begin
        r_msg_cmd     <= r_cmd_stage;
        r_msg_payload <= {r_pay_stage, w_word};
      end
    end
  end

  assign MSG_VALID      = r_msg_valid;
  assign MSG_CMD        = r_msg_cmd;
  assign MSG_PAYLOAD    = r_msg_payload;
  assign BOARD_MODE_REQ = r_bmr;
  assign MSG_ERR        = r_err;

endmodule

// File: tb/tb_input_process_spi.sv
// Scoreboard bench for input_process_spi: stimulus pushes expected messages
// and error pulses into queues; a monitor pops and compares on DUT strobes.
module tb_input_process_spi;

  localparam int unsigned TIMEOUT  = 64;
  localparam int          GAP_IDLE = TIMEOUT - 1 - 16;

  logic        RST;
  logic        RX_CLK;
  logic        RX_DATA;
  logic        RX_LOAD;
  logic        MSG_VALID;
  logic [15:0] MSG_CMD;
  logic [63:0] MSG_PAYLOAD;
  logic        BOARD_MODE_REQ;
  logic        MSG_ERR;

  typedef struct {
    logic [15:0] cmd;
    logic [63:0] pay;
    logic        bmr;
    int          cyc;
  } exp_msg_t;

  exp_msg_t expQ[$];
  int       errQ[$];
  int       tests = 0;
  int       fails = 0;
  int       cyc   = 0;

  input_process_spi #(
    .HEADER         (16'h55AA),
    .BOARD_MODE_CMD (16'h0082),
    .TIMEOUT        (TIMEOUT)
  ) dut (
    .RST            (RST),
    .RX_CLK         (RX_CLK),
    .RX_DATA        (RX_DATA),
    .RX_LOAD        (RX_LOAD),
    .MSG_VALID      (MSG_VALID),
    .MSG_CMD        (MSG_CMD),
    .MSG_PAYLOAD    (MSG_PAYLOAD),
    .BOARD_MODE_REQ (BOARD_MODE_REQ),
    .MSG_ERR        (MSG_ERR)
  );

  initial RX_CLK = 1'b0;
  always #5 RX_CLK = ~RX_CLK;

  always @(posedge RX_CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic sendWord(input logic [15:0] w, output int loadCyc);
    for (int i = 15; i >= 0; i--) begin
      @(negedge RX_CLK);
      RX_DATA = w[i];
      RX_LOAD = (i == 0);
    end
    loadCyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge RX_CLK);
      RX_DATA = 1'b0;
      RX_LOAD = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] h, input logic [15:0] c,
                               input logic [15:0] p0, input logic [15:0] p1,
                               input logic [15:0] p2, input logic [15:0] p3,
                               input logic [63:0] expPay, input logic expBmr,
                               input int gap);
    logic [15:0] words [6];
    int lc;
    exp_msg_t e;
    words[0] = h;  words[1] = c;  words[2] = p0;
    words[3] = p1; words[4] = p2; words[5] = p3;
    for (int k = 0; k < 6; k++) begin
      sendWord(words[k], lc);
      if (k < 5 && gap > 0) idle(gap);
    end
    e.cmd = c;
    e.pay = expPay;
    e.bmr = expBmr;
    e.cyc = lc + 2;
    expQ.push_back(e);
  endtask

  task automatic applyPartial(input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic expectErr);
    int lc;
    sendWord(w0, lc);
    sendWord(w1, lc);
    sendWord(w2, lc);
    if (expectErr) errQ.push_back(lc + 2 + TIMEOUT);
  endtask

  // Monitor: compares every DUT strobe against the scoreboard queues.
  always @(negedge RX_CLK) begin
    exp_msg_t e;
    int ec;
    if (MSG_VALID === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_msg_valid", 64'd1, 64'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("msg_cmd", {48'd0, MSG_CMD}, {48'd0, e.cmd});
        checkOutput("msg_payload", MSG_PAYLOAD, e.pay);
        checkOutput("board_mode_req", {63'd0, BOARD_MODE_REQ}, {63'd0, e.bmr});
        checkOutput("msg_valid_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else begin
      if (BOARD_MODE_REQ === 1'b1) checkOutput("bmr_without_valid", 64'd1, 64'd0);
    end
    if (MSG_ERR === 1'b1) begin
      if (errQ.size() == 0) begin
        checkOutput("unexpected_msg_err", 64'd1, 64'd0);
      end else begin
        ec = errQ.pop_front();
        checkOutput("msg_err_cycle", 64'(cyc), 64'(ec));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST     = 1'b0;
    RX_DATA = 1'b0;
    RX_LOAD = 1'b0;
    repeat (3) @(negedge RX_CLK);
    checkOutput("reset_valid",   {63'd0, MSG_VALID},      64'd0);
    checkOutput("reset_bmr",     {63'd0, BOARD_MODE_REQ}, 64'd0);
    checkOutput("reset_err",     {63'd0, MSG_ERR},        64'd0);
    checkOutput("reset_cmd",     {48'd0, MSG_CMD},        64'd0);
    checkOutput("reset_payload", MSG_PAYLOAD,             64'd0);
    RST = 1'b1;
    idle(4);

    // Back-to-back: board-mode msg, leading garbage, normal msg, header-as-data msg.
    applyStimulus(16'h55AA, 16'h0082, 16'h0001, 16'h1000, 16'h0000, 16'h0000,
                  64'h0001_1000_0000_0000, 1'b1, 0);
    begin
      int lc;
      sendWord(16'h1234, lc);
      sendWord(16'hABCD, lc);
    end
    applyStimulus(16'h55AA, 16'h0005, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
                  64'h1111_2222_3333_4444, 1'b0, 0);
    applyStimulus(16'h55AA, 16'h0003, 16'h55AA, 16'h0000, 16'h0000, 16'h0001,
                  64'h55AA_0000_0000_0001, 1'b0, 0);
    idle(10);

    // Timeout on a partial message; outputs keep the last accepted message.
    applyPartial(16'h55AA, 16'h0082, 16'h0001, 1'b1);
    idle(TIMEOUT + 20);
    checkOutput("hold_cmd_after_timeout", {48'd0, MSG_CMD}, 64'h0003);
    checkOutput("hold_payload_after_timeout", MSG_PAYLOAD, 64'h55AA_0000_0000_0001);

    applyStimulus(16'h55AA, 16'h0082, 16'hCAFE, 16'h0000, 16'h0000, 16'h0002,
                  64'hCAFE_0000_0000_0002, 1'b1, 0);
    idle(4);

    // Reset in the middle of a message.
    applyPartial(16'h55AA, 16'h0011, 16'h2222, 1'b0);
    @(negedge RX_CLK);
    RX_LOAD = 1'b0;
    RX_DATA = 1'b0;
    RST     = 1'b0;
    #1;
    checkOutput("midreset_valid",   {63'd0, MSG_VALID},      64'd0);
    checkOutput("midreset_bmr",     {63'd0, BOARD_MODE_REQ}, 64'd0);
    checkOutput("midreset_err",     {63'd0, MSG_ERR},        64'd0);
    checkOutput("midreset_cmd",     {48'd0, MSG_CMD},        64'd0);
    checkOutput("midreset_payload", MSG_PAYLOAD,             64'd0);
    idle(3);
    RST = 1'b1;
    idle(2);
    applyStimulus(16'h55AA, 16'h0007, 16'hDEAD, 16'hBEEF, 16'h0123, 16'h4567,
                  64'hDEAD_BEEF_0123_4567, 1'b0, 0);
    idle(4);

    // Word strobes spaced TIMEOUT-1 cycles apart must still be accepted.
    applyStimulus(16'h55AA, 16'h0009, 16'h0A0B, 16'h0C0D, 16'h0E0F, 16'h1011,
                  64'h0A0B_0C0D_0E0F_1011, 1'b0, GAP_IDLE);
    idle(10);

    checkOutput("pending_msgs", 64'(expQ.size()), 64'd0);
    checkOutput("pending_errs", 64'(errQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
